// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// Package : mips_pkg
// Brief   : Shared constants for the MIPS pipeline. Holds opcodes, the bit
//           positions inside the wb/m/ex control bundles, ALU_OP encodings
//           and the control-bundle struct used by the ID stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    // Opcodes (instr[31:26]) recognised by the ID-stage control decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    // Bundle widths
    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    // wb bundle: {reg_write, mem_to_reg}
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    // m bundle: {branch, mem_read, mem_write}
    localparam int M_BRANCH    = 2;
    localparam int M_MEM_READ  = 1;
    localparam int M_MEM_WRITE = 0;

    // ex bundle: {reg_dst, alu_op[1:0], alu_src}
    localparam int EX_REG_DST   = 3;
    localparam int EX_ALU_OP_HI = 2;
    localparam int EX_ALU_OP_LO = 1;
    localparam int EX_ALU_SRC   = 0;

    // ALU_OP encodings carried to the EX stage
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;   // address calculation
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;   // branch compare
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;   // EX looks at funct field

    // Complete control word produced by the decoder
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/reg_file.sv
//------------------------------------------------------------------------------
// Module  : reg_file
// Brief   : General-purpose register file, 2 async read ports / 1 write port.
//           Register 0 is hardwired to zero. A write in progress is visible
//           on the read ports in the same cycle (write->read bypass).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              write_en;

    assign write_en = we && (waddr != '0);

    // Next register contents; doubles as the bypass source for the read ports
    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Register array update, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads go through regs_d so a same-cycle write is returned immediately
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs_d[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs_d[raddr2];
    end

endmodule : reg_file

`default_nettype wire

// File: rtl/decode.sv
//------------------------------------------------------------------------------
// Module  : decode
// Brief   : ID stage of the 5-stage MIPS pipeline. Decodes the instruction
//           from IF/ID, reads the register file, sign-extends the immediate
//           and registers everything into the ID/EX latch. Also hosts the
//           register-file write port driven by the MEM/WB write-back path.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           if_id_instr,
    input  logic [31:0]           if_id_npc,
    input  logic                  flush,
    input  logic                  mem_wb_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_wb_write_reg,
    input  logic [DATA_W-1:0]     mem_wb_write_data,
    output logic [WB_W-1:0]       id_ex_wb,
    output logic [M_W-1:0]        id_ex_m,
    output logic [EX_W-1:0]       id_ex_ex,
    output logic [31:0]           id_ex_npc,
    output logic [DATA_W-1:0]     id_ex_rd1,
    output logic [DATA_W-1:0]     id_ex_rd2,
    output logic [DATA_W-1:0]     id_ex_sign_ext,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_rd
);

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     gpr_rs;
    logic [DATA_W-1:0]     gpr_rt;

    ctrl_t                 ctrl_d, ctrl_q;
    logic [31:0]           npc_d, npc_q;
    logic [DATA_W-1:0]     rd1_d, rd1_q;
    logic [DATA_W-1:0]     rd2_d, rd2_q;
    logic [DATA_W-1:0]     sign_ext_d, sign_ext_q;
    logic [REG_ADDR_W-1:0] rt_d, rt_q;
    logic [REG_ADDR_W-1:0] rd_d, rd_q;

    assign opcode = if_id_instr[31:26];
    assign rs     = if_id_instr[21 +: REG_ADDR_W];
    assign rt     = if_id_instr[16 +: REG_ADDR_W];
    assign rd     = if_id_instr[11 +: REG_ADDR_W];

    reg_file #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (gpr_rs),
        .rdata2 (gpr_rt),
        .we     (mem_wb_reg_write),
        .waddr  (mem_wb_write_reg),
        .wdata  (mem_wb_write_data)
    );

    // Control decode; unknown opcodes and flushes produce an all-zero bubble
    always_comb begin
        ctrl_d = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_d.wb[WB_REG_WRITE]                  = 1'b1;
                ctrl_d.ex[EX_REG_DST]                    = 1'b1;
                ctrl_d.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]     = ALU_OP_FUNCT;
            end
            OP_LW: begin
                ctrl_d.wb[WB_REG_WRITE]                  = 1'b1;
                ctrl_d.wb[WB_MEM_TO_REG]                 = 1'b1;
                ctrl_d.m[M_MEM_READ]                     = 1'b1;
                ctrl_d.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]     = ALU_OP_ADD;
                ctrl_d.ex[EX_ALU_SRC]                    = 1'b1;
            end
            OP_SW: begin
                ctrl_d.m[M_MEM_WRITE]                    = 1'b1;
                ctrl_d.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]     = ALU_OP_ADD;
                ctrl_d.ex[EX_ALU_SRC]                    = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.m[M_BRANCH]                       = 1'b1;
                ctrl_d.ex[EX_ALU_OP_HI:EX_ALU_OP_LO]     = ALU_OP_SUB;
            end
            default: ctrl_d = '0;
        endcase
        if (flush) begin
            ctrl_d = '0;
        end
    end

    // Data fields are latched regardless of flush or opcode
    always_comb begin
        npc_d      = if_id_npc;
        rd1_d      = gpr_rs;
        rd2_d      = gpr_rt;
        sign_ext_d = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
        rt_d       = rt;
        rd_d       = rd;
    end

    // ID/EX pipeline latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            npc_q      <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            sign_ext_q <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            npc_q      <= npc_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            sign_ext_q <= sign_ext_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
        end
    end

    assign id_ex_wb       = ctrl_q.wb;
    assign id_ex_m        = ctrl_q.m;
    assign id_ex_ex       = ctrl_q.ex;
    assign id_ex_npc      = npc_q;
    assign id_ex_rd1      = rd1_q;
    assign id_ex_rd2      = rd2_q;
    assign id_ex_sign_ext = sign_ext_q;
    assign id_ex_rt       = rt_q;
    assign id_ex_rd       = rd_q;

endmodule : decode

`default_nettype wire

// File: tb/tb_decode.sv
//------------------------------------------------------------------------------
// Module  : tb_decode
// Brief   : Self-checking bench for the ID stage. Directed scenarios plus a
//           randomized stream checked against a behavioural reference model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode;

    logic        clk;
    logic        rst;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        flush;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_write_reg;
    logic [31:0] mem_wb_write_data;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_m;
    logic [3:0]  id_ex_ex;
    logic [31:0] id_ex_npc;
    logic [31:0] id_ex_rd1;
    logic [31:0] id_ex_rd2;
    logic [31:0] id_ex_sign_ext;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_rd;

    int checks;
    int failures;

    // Reference model state and expected outputs
    logic [31:0] gpr [32];
    logic [1:0]  exp_wb;
    logic [2:0]  exp_m;
    logic [3:0]  exp_ex;
    logic [31:0] exp_npc, exp_rd1, exp_rd2, exp_sext;
    logic [4:0]  exp_rt, exp_rd;

    decode dut (
        .clk               (clk),
        .rst               (rst),
        .if_id_instr       (if_id_instr),
        .if_id_npc         (if_id_npc),
        .flush             (flush),
        .mem_wb_reg_write  (mem_wb_reg_write),
        .mem_wb_write_reg  (mem_wb_write_reg),
        .mem_wb_write_data (mem_wb_write_data),
        .id_ex_wb          (id_ex_wb),
        .id_ex_m           (id_ex_m),
        .id_ex_ex          (id_ex_ex),
        .id_ex_npc         (id_ex_npc),
        .id_ex_rd1         (id_ex_rd1),
        .id_ex_rd2         (id_ex_rd2),
        .id_ex_sign_ext    (id_ex_sign_ext),
        .id_ex_rt          (id_ex_rt),
        .id_ex_rd          (id_ex_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control table from the instruction set: {wb, m, ex}
    function automatic logic [8:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return {2'b10, 3'b000, 4'b1100};
            6'h23:   return {2'b11, 3'b010, 4'b0001};
            6'h2B:   return {2'b00, 3'b001, 4'b0001};
            6'h04:   return {2'b00, 3'b100, 4'b0010};
            default: return 9'd0;
        endcase
    endfunction

    // Model one ID cycle (write-back lands first, then the reads see it), drive it and clock it
    task automatic cycle(input logic [31:0] instr, input logic [31:0] npc, input logic fl,
                         input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
        logic [8:0] c;
        if (we && wreg != 5'd0) gpr[wreg] = wdata;
        c        = fl ? 9'd0 : ref_ctrl(instr[31:26]);
        exp_wb   = c[8:7];
        exp_m    = c[6:4];
        exp_ex   = c[3:0];
        exp_npc  = npc;
        exp_rd1  = gpr[instr[25:21]];
        exp_rd2  = gpr[instr[20:16]];
        exp_sext = {{16{instr[15]}}, instr[15:0]};
        exp_rt   = instr[20:16];
        exp_rd   = instr[15:11];
        if_id_instr       = instr;
        if_id_npc         = npc;
        flush             = fl;
        mem_wb_reg_write  = we;
        mem_wb_write_reg  = wreg;
        mem_wb_write_data = wdata;
        @(posedge clk);
        #1;
        mem_wb_reg_write  = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) gpr[i] = 32'd0;
    endtask

    task automatic test_reset();
        // reset state after power-up reset
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_sign_ext, id_ex_rt, id_ex_rd} !== '0) begin
            failures++; $display("FAIL reset_init got wb=%b m=%b ex=%b npc=%h exp all zero", id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc);
        end
        // fill some registers and a nonzero latch, then reset mid-cycle
        cycle(32'h0, 32'h4, 1'b0, 1'b1, 5'd1, 32'h1111_1111);
        cycle(32'h0, 32'h8, 1'b0, 1'b1, 5'd31, 32'hDEAD_BEEF);
        cycle(32'h8FA8_FFFC, 32'h44, 1'b0, 1'b1, 5'd8, 32'h0000_0088);
        checks++;
        if (id_ex_wb !== 2'b11 || id_ex_npc !== 32'h44) begin
            failures++; $display("FAIL reset_pre got wb=%b npc=%h exp wb=11 npc=00000044", id_ex_wb, id_ex_npc);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_rd1, id_ex_rd2, id_ex_sign_ext, id_ex_rt, id_ex_rd} !== '0) begin
            failures++; $display("FAIL reset_async got wb=%b m=%b ex=%b npc=%h sext=%h exp all zero", id_ex_wb, id_ex_m, id_ex_ex, id_ex_npc, id_ex_sign_ext);
        end
        #1 rst = 1'b0;
        clear_model();
        // every GPR reads zero afterwards
        for (int i = 0; i < 32; i++) begin
            logic [4:0] r;
            r = 5'(i);
            cycle({6'h00, r, r, 5'd0, 11'd0}, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
            checks++;
            if (id_ex_rd1 !== 32'd0 || id_ex_rd2 !== 32'd0) begin
                failures++; $display("FAIL reset_gpr%0d got rd1=%h rd2=%h exp 0", i, id_ex_rd1, id_ex_rd2);
            end
        end
    endtask

    task automatic test_rtype();
        cycle(32'h0, 32'h0, 1'b0, 1'b1, 5'd8, 32'h0000_00AA);
        cycle(32'h0109_1820, 32'h0000_0020, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (id_ex_rd1 !== 32'hAA || id_ex_rd2 !== 32'h0 || id_ex_rt !== 5'd9 || id_ex_rd !== 5'd3) begin
            failures++; $display("FAIL rtype_data got rd1=%h rd2=%h rt=%0d rd=%0d exp 000000aa 00000000 9 3", id_ex_rd1, id_ex_rd2, id_ex_rt, id_ex_rd);
        end
        checks++;
        if (id_ex_wb !== 2'b10 || id_ex_m !== 3'b000 || id_ex_ex !== 4'b1100) begin
            failures++; $display("FAIL rtype_ctrl got wb=%b m=%b ex=%b exp 10 000 1100", id_ex_wb, id_ex_m, id_ex_ex);
        end
    endtask

    task automatic test_lw();
        cycle(32'h8FA8_FFFC, 32'h0000_0010, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (id_ex_sign_ext !== 32'hFFFF_FFFC || id_ex_rt !== 5'd8 || id_ex_npc !== 32'h10) begin
            failures++; $display("FAIL lw_data got sext=%h rt=%0d npc=%h exp fffffffc 8 00000010", id_ex_sign_ext, id_ex_rt, id_ex_npc);
        end
        checks++;
        if (id_ex_wb !== 2'b11 || id_ex_m !== 3'b010 || id_ex_ex !== 4'b0001) begin
            failures++; $display("FAIL lw_ctrl got wb=%b m=%b ex=%b exp 11 010 0001", id_ex_wb, id_ex_m, id_ex_ex);
        end
    endtask

    task automatic test_bypass();
        cycle(32'h10A5_0003, 32'h0000_0030, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        checks++;
        if (id_ex_rd1 !== 32'h1234 || id_ex_rd2 !== 32'h1234 || id_ex_sign_ext !== 32'h3) begin
            failures++; $display("FAIL bypass_data got rd1=%h rd2=%h sext=%h exp 00001234 00001234 00000003", id_ex_rd1, id_ex_rd2, id_ex_sign_ext);
        end
        checks++;
        if (id_ex_wb !== 2'b00 || id_ex_m !== 3'b100 || id_ex_ex !== 4'b0010) begin
            failures++; $display("FAIL beq_ctrl got wb=%b m=%b ex=%b exp 00 100 0010", id_ex_wb, id_ex_m, id_ex_ex);
        end
    endtask

    task automatic test_zero_reg();
        // write to $0 while reading $0 in the same cycle: must still read 0
        cycle(32'h0000_0000, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        checks++;
        if (id_ex_rd1 !== 32'd0) begin
            failures++; $display("FAIL zero_bypass got rd1=%h exp 00000000", id_ex_rd1);
        end
        cycle(32'h0000_0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (id_ex_rd1 !== 32'd0 || id_ex_rd2 !== 32'd0) begin
            failures++; $display("FAIL zero_read got rd1=%h rd2=%h exp 0", id_ex_rd1, id_ex_rd2);
        end
    endtask

    task automatic test_flush();
        // flush together with a write-back: write still lands, control bubbles
        cycle(32'h10A5_0003, 32'h0000_0040, 1'b1, 1'b1, 5'd7, 32'h0000_7777);
        checks++;
        if (id_ex_wb !== 2'b00 || id_ex_m !== 3'b000 || id_ex_ex !== 4'b0000) begin
            failures++; $display("FAIL flush_ctrl got wb=%b m=%b ex=%b exp 0", id_ex_wb, id_ex_m, id_ex_ex);
        end
        checks++;
        if (id_ex_rd1 !== 32'h1234 || id_ex_rd2 !== 32'h1234 || id_ex_npc !== 32'h40) begin
            failures++; $display("FAIL flush_data got rd1=%h rd2=%h npc=%h exp 00001234 00001234 00000040", id_ex_rd1, id_ex_rd2, id_ex_npc);
        end
        cycle({6'h00, 5'd7, 5'd0, 16'd0}, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (id_ex_rd1 !== 32'h7777) begin
            failures++; $display("FAIL flush_wb_write got rd1=%h exp 00007777", id_ex_rd1);
        end
        cycle(32'hFCA5_0003, 32'h0000_0050, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (id_ex_wb !== 2'b00 || id_ex_m !== 3'b000 || id_ex_ex !== 4'b0000 || id_ex_rd1 !== 32'h1234) begin
            failures++; $display("FAIL illegal_op got wb=%b m=%b ex=%b rd1=%h exp 0 0 0 00001234", id_ex_wb, id_ex_m, id_ex_ex, id_ex_rd1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic [31:0] r, instr, wdata;
            logic [5:0]  op;
            logic [4:0]  wreg;
            logic        fl, we;
            case ($urandom_range(0, 4))
                0:       op = 6'h00;
                1:       op = 6'h23;
                2:       op = 6'h2B;
                3:       op = 6'h04;
                default: op = 6'($urandom_range(0, 63));
            endcase
            r     = $urandom();
            instr = {op, r[25:0]};
            fl    = ($urandom_range(0, 7) == 0);
            we    = ($urandom_range(0, 1) == 1);
            r     = $urandom();
            wreg  = ($urandom_range(0, 2) == 0) ? instr[25:21] : r[4:0];
            wdata = $urandom();
            cycle(instr, $urandom(), fl, we, wreg, wdata);
            checks++;
            if (id_ex_wb !== exp_wb || id_ex_m !== exp_m || id_ex_ex !== exp_ex) begin
                failures++; $display("FAIL rand_ctrl[%0d] instr=%h flush=%b got %b_%b_%b exp %b_%b_%b", n, instr, fl, id_ex_wb, id_ex_m, id_ex_ex, exp_wb, exp_m, exp_ex);
            end
            checks++;
            if (id_ex_rd1 !== exp_rd1 || id_ex_rd2 !== exp_rd2) begin
                failures++; $display("FAIL rand_regs[%0d] instr=%h got rd1=%h rd2=%h exp %h %h", n, instr, id_ex_rd1, id_ex_rd2, exp_rd1, exp_rd2);
            end
            checks++;
            if (id_ex_npc !== exp_npc || id_ex_sign_ext !== exp_sext || id_ex_rt !== exp_rt || id_ex_rd !== exp_rd) begin
                failures++; $display("FAIL rand_fields[%0d] got npc=%h sext=%h rt=%0d rd=%0d exp %h %h %0d %0d", n, id_ex_npc, id_ex_sign_ext, id_ex_rt, id_ex_rd, exp_npc, exp_sext, exp_rt, exp_rd);
            end
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        if_id_instr       = 32'd0;
        if_id_npc         = 32'd0;
        flush             = 1'b0;
        mem_wb_reg_write  = 1'b0;
        mem_wb_write_reg  = 5'd0;
        mem_wb_write_data = 32'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        test_reset();
        test_rtype();
        test_lw();
        test_bypass();
        test_zero_reg();
        test_flush();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decode

`default_nettype wire
